// File: rtl/decode_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage_pkg
//  Description : Shared constants, instruction field positions and immediate
//                extension helper for the CHARIS decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package decode_stage_pkg;

    localparam int DATA_W = 32;

    localparam int c_OPCODE_MSB = 31;
    localparam int c_OPCODE_LSB = 26;
    localparam int c_RS_MSB     = 25;
    localparam int c_RS_LSB     = 21;
    localparam int c_RD_MSB     = 20;
    localparam int c_RD_LSB     = 16;
    localparam int c_RT_MSB     = 15;
    localparam int c_RT_LSB     = 11;
    localparam int c_IMM_MSB    = 15;
    localparam int c_IMM_LSB    = 0;

    typedef enum logic [1:0] {
        IMM_ZERO = 2'b00,
        IMM_SIGN = 2'b01,
        IMM_LUI  = 2'b10,
        IMM_BR   = 2'b11
    } imm_ext_e;

    // Branch mode drops the two sign bits that shift past bit 31.
    function automatic logic [31:0] imm_extend(input logic [15:0] imm16, input imm_ext_e mode);
        logic [31:0] w_sext;
        logic [31:0] w_res;
        w_sext = {{16{imm16[15]}}, imm16};
        w_res  = '0;
        unique case (mode)
            IMM_ZERO: w_res = {16'h0000, imm16};
            IMM_SIGN: w_res = w_sext;
            IMM_LUI:  w_res = {imm16, 16'h0000};
            IMM_BR:   w_res = {w_sext[29:0], 2'b00};
            default:  w_res = '0;
        endcase
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage_if
//  Description : Datapath/control bundle between the decode stage and the
//                surrounding fetch/execute/memory logic.
//  Revision    : 1.0 - initial release
// ============================================================================
interface decode_stage_if #(
    parameter int DATA_W = 32
) ();

    logic [31:0]       Instr;
    logic [DATA_W-1:0] ALU_out;
    logic [DATA_W-1:0] MEM_out;
    logic              RF_WrEn;
    logic              RF_WrData_sel;
    logic              RF_B_sel;
    logic [1:0]        ImmExt;
    logic              Dec_LdEn;
    logic [DATA_W-1:0] RF_A;
    logic [DATA_W-1:0] RF_B;
    logic [DATA_W-1:0] Immed;

    modport master (
        output Instr, ALU_out, MEM_out, RF_WrEn, RF_WrData_sel, RF_B_sel, ImmExt, Dec_LdEn,
        input  RF_A, RF_B, Immed
    );

    modport slave (
        input  Instr, ALU_out, MEM_out, RF_WrEn, RF_WrData_sel, RF_B_sel, ImmExt, Dec_LdEn,
        output RF_A, RF_B, Immed
    );

endinterface
`default_nettype wire

// File: rtl/decode_stage_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : register_file
//  Description : Two combinational read ports, one synchronous write port,
//                R0 hardwired to zero, synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file #(
    parameter int REG_COUNT = 32,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = $clog2(REG_COUNT)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [ADDR_W-1:0] i_ra_addr,
    output logic      [DATA_W-1:0] o_ra_data,
    input  wire logic [ADDR_W-1:0] i_rb_addr,
    output logic      [DATA_W-1:0] o_rb_data,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_waddr,
    input  wire logic [DATA_W-1:0] i_wdata
);

    logic [DATA_W-1:0] w_regs [REG_COUNT];

    // Entry 0 has no storage at all, so writes to it vanish by construction.
    for (genvar g = 0; g < REG_COUNT; g++) begin : g_regs
        if (g == 0) begin : g_zero
            assign w_regs[g] = '0;
        end else begin : g_store
            logic [DATA_W-1:0] r_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_q <= '0;
                end else if (i_we && (i_waddr == ADDR_W'(g))) begin
                    r_q <= i_wdata;
                end
            end
            assign w_regs[g] = r_q;
        end
    end

    assign o_ra_data = w_regs[i_ra_addr];
    assign o_rb_data = w_regs[i_rb_addr];

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : CHARIS decode stage - register file, write-back, immediate
//                extension and operand output registers with write-first bypass.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter int REG_COUNT = 32,
    parameter int DATA_W    = decode_stage_pkg::DATA_W
) (
    input  wire logic     Clk,
    input  wire logic     Reset,
    decode_stage_if.slave bus
);

    import decode_stage_pkg::*;

    localparam int c_ADDR_W = $clog2(REG_COUNT);

    logic [c_ADDR_W-1:0] w_rs;
    logic [c_ADDR_W-1:0] w_rd;
    logic [c_ADDR_W-1:0] w_rt;
    logic [c_ADDR_W-1:0] w_b_addr;
    logic [DATA_W-1:0]   w_wr_data;
    logic [DATA_W-1:0]   w_ra_data;
    logic [DATA_W-1:0]   w_rb_data;
    logic [DATA_W-1:0]   w_a_next;
    logic [DATA_W-1:0]   w_b_next;
    logic [DATA_W-1:0]   w_imm;
    logic                w_wr_live;

    logic [DATA_W-1:0]   r_rf_a;
    logic [DATA_W-1:0]   r_rf_b;
    logic [DATA_W-1:0]   r_immed;

    assign w_rs      = c_ADDR_W'(bus.Instr[c_RS_MSB:c_RS_LSB]);
    assign w_rd      = c_ADDR_W'(bus.Instr[c_RD_MSB:c_RD_LSB]);
    assign w_rt      = c_ADDR_W'(bus.Instr[c_RT_MSB:c_RT_LSB]);
    assign w_b_addr  = bus.RF_B_sel ? w_rd : w_rt;
    assign w_wr_data = bus.RF_WrData_sel ? bus.MEM_out : bus.ALU_out;

    register_file #(
        .REG_COUNT (REG_COUNT),
        .DATA_W    (DATA_W),
        .ADDR_W    (c_ADDR_W)
    ) u_register_file (
        .clk       (Clk),
        .rst       (Reset),
        .i_ra_addr (w_rs),
        .o_ra_data (w_ra_data),
        .i_rb_addr (w_b_addr),
        .o_rb_data (w_rb_data),
        .i_we      (bus.RF_WrEn),
        .i_waddr   (w_rd),
        .i_wdata   (w_wr_data)
    );

    // Same-edge write wins over the stale array value; R0 never bypasses.
    assign w_wr_live = bus.RF_WrEn && (w_rd != '0);
    assign w_a_next  = (w_wr_live && (w_rs == w_rd))     ? w_wr_data : w_ra_data;
    assign w_b_next  = (w_wr_live && (w_b_addr == w_rd)) ? w_wr_data : w_rb_data;
    assign w_imm     = DATA_W'(imm_extend(bus.Instr[c_IMM_MSB:c_IMM_LSB], imm_ext_e'(bus.ImmExt)));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rf_a  <= '0;
            r_rf_b  <= '0;
            r_immed <= '0;
        end else if (bus.Dec_LdEn) begin
            r_rf_a  <= w_a_next;
            r_rf_b  <= w_b_next;
            r_immed <= w_imm;
        end
    end

    assign bus.RF_A  = r_rf_a;
    assign bus.RF_B  = r_rf_b;
    assign bus.Immed = r_immed;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Self-checking bench for decode_stage: directed vector table,
//                hand-written reset sequences and randomized model comparison.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    decode_stage_if #(.DATA_W(32)) bus ();

    decode_stage #(
        .REG_COUNT (32),
        .DATA_W    (32)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic [31:0] alu;
        logic [31:0] mem;
        logic        wren;
        logic        wsel;
        logic        bsel;
        logic [1:0]  ext;
        logic        ld;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [31:0] exp_imm;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [31:0] m_imm;

    vec_t vecs [$];

    function automatic vec_t mk(input logic r, input logic [31:0] instr, input logic [31:0] alu,
                                input logic [31:0] mem, input logic wren, input logic wsel,
                                input logic bsel, input logic [1:0] ext, input logic ld,
                                input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ei);
        vec_t v;
        v.rst = r; v.instr = instr; v.alu = alu; v.mem = mem;
        v.wren = wren; v.wsel = wsel; v.bsel = bsel; v.ext = ext; v.ld = ld;
        v.exp_a = ea; v.exp_b = eb; v.exp_imm = ei;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: reads see the value being written this edge, except R0.
    task automatic model_step(input vec_t v);
        int          rs, rd, rt, rb;
        logic [31:0] wd;
        logic [15:0] imm;
        int signed   s;
        if (v.rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_a = '0; m_b = '0; m_imm = '0;
            return;
        end
        rs  = int'(v.instr[25:21]);
        rd  = int'(v.instr[20:16]);
        rt  = int'(v.instr[15:11]);
        rb  = v.bsel ? rd : rt;
        wd  = v.wsel ? v.mem : v.alu;
        imm = v.instr[15:0];
        s   = int'($signed(imm));
        if (v.ld) begin
            m_a = (rs == 0) ? 32'h0 : ((v.wren && rs == rd) ? wd : m_regs[rs]);
            m_b = (rb == 0) ? 32'h0 : ((v.wren && rb == rd) ? wd : m_regs[rb]);
            case (v.ext)
                2'd0:    m_imm = 32'(imm);
                2'd1:    m_imm = 32'(s);
                2'd2:    m_imm = 32'(imm) << 16;
                default: m_imm = 32'(s * 4);
            endcase
        end
        if (v.wren && rd != 0) m_regs[rd] = wd;
    endtask

    task automatic drive(input vec_t v);
        rst               = v.rst;
        bus.Instr         = v.instr;
        bus.ALU_out       = v.alu;
        bus.MEM_out       = v.mem;
        bus.RF_WrEn       = v.wren;
        bus.RF_WrData_sel = v.wsel;
        bus.RF_B_sel      = v.bsel;
        bus.ImmExt        = v.ext;
        bus.Dec_LdEn      = v.ld;
    endtask

    task automatic apply(input vec_t v);
        drive(v);
        model_step(v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;

        vecs.push_back(mk(1, 32'h0000_0000, 0, 0, 0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 32'h0062_1800, 0, 0, 0, 0, 0, 2'd0, 1, 32'h0, 32'h0, 32'h0000_1800));
        vecs.push_back(mk(0, 32'h0000_FFFC, 0, 0, 0, 0, 0, 2'd0, 1, 32'h0, 32'h0, 32'h0000_FFFC));
        vecs.push_back(mk(0, 32'h0000_FFFC, 0, 0, 0, 0, 0, 2'd1, 1, 32'h0, 32'h0, 32'hFFFF_FFFC));
        vecs.push_back(mk(0, 32'h0000_FFFC, 0, 0, 0, 0, 0, 2'd2, 1, 32'h0, 32'h0, 32'hFFFC_0000));
        vecs.push_back(mk(0, 32'h0000_FFFC, 0, 0, 0, 0, 0, 2'd3, 1, 32'h0, 32'h0, 32'hFFFF_FFF0));
        vecs.push_back(mk(0, 32'h0005_0000, 32'hDEAD_BEEF, 0, 1, 0, 0, 2'd0, 0, 32'h0, 32'h0, 32'hFFFF_FFF0));
        vecs.push_back(mk(0, 32'h00A0_0000, 0, 0, 0, 0, 0, 2'd0, 1, 32'hDEAD_BEEF, 32'h0, 32'h0));
        vecs.push_back(mk(0, 32'h0000_0000, 32'h0000_0055, 0, 1, 0, 0, 2'd0, 0, 32'hDEAD_BEEF, 32'h0, 32'h0));
        vecs.push_back(mk(0, 32'h0000_0000, 0, 0, 0, 0, 0, 2'd0, 1, 32'h0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 32'h0007_0000, 32'hAAAA_AAAA, 32'h1234_5678, 1, 1, 1, 2'd0, 1, 32'h0, 32'h1234_5678, 32'h0));
        vecs.push_back(mk(0, 32'h0129_0000, 32'hCAFE_F00D, 0, 1, 0, 1, 2'd0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'h0));
        vecs.push_back(mk(0, 32'h00A7_1234, 32'h1111_1111, 0, 1, 0, 1, 2'd1, 0, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'h0));
        vecs.push_back(mk(0, 32'h00A7_1234, 0, 0, 0, 0, 1, 2'd1, 1, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_1234));
        vecs.push_back(mk(0, 32'h00A7_4800, 0, 0, 0, 0, 0, 2'd0, 1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_4800));
        vecs.push_back(mk(1, 32'h0003_0000, 32'h3333_3333, 0, 1, 0, 0, 2'd0, 1, 32'h0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 32'h0060_2800, 0, 0, 0, 0, 0, 2'd0, 1, 32'h0, 32'h0, 32'h0000_2800));
        vecs.push_back(mk(0, 32'h0003_0000, 32'h0BAD_CAFE, 0, 1, 0, 0, 2'd0, 0, 32'h0, 32'h0, 32'h0000_2800));
        vecs.push_back(mk(0, 32'h0060_0000, 0, 0, 0, 0, 0, 2'd0, 1, 32'h0BAD_CAFE, 32'h0, 32'h0));

        drive(vecs[0]);
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            check($sformatf("vec%0d RF_A", i),  bus.RF_A,  vecs[i].exp_a);
            check($sformatf("vec%0d RF_B", i),  bus.RF_B,  vecs[i].exp_b);
            check($sformatf("vec%0d Immed", i), bus.Immed, vecs[i].exp_imm);
        end

        // Fill several registers, reset, then every register must read zero.
        for (int r = 1; r < 32; r += 3) begin
            v = mk(0, {11'h0, 5'(r), 16'h0}, 32'h5A5A_0000 + 32'(r), 0, 1, 0, 0, 2'd0, 0, 0, 0, 0);
            apply(v);
        end
        v = mk(1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
        apply(v);
        for (int r = 0; r < 32; r++) begin
            v = mk(0, {6'h0, 5'(r), 5'h0, 5'(r), 11'h0}, 0, 0, 0, 0, 0, 2'd0, 1, 0, 0, 0);
            apply(v);
            check($sformatf("post-reset R%0d A", r), bus.RF_A, 32'h0);
            check($sformatf("post-reset R%0d B", r), bus.RF_B, 32'h0);
        end

        // Write then read on the very next cycle through both ports.
        v = mk(0, 32'h000B_0000, 0, 32'h7777_0001, 1, 1, 0, 2'd0, 0, 0, 0, 0);
        apply(v);
        v = mk(0, 32'h016B_5800, 0, 0, 0, 0, 1, 2'd0, 1, 0, 0, 0);
        apply(v);
        check("b2b RF_A", bus.RF_A, 32'h7777_0001);
        check("b2b RF_B", bus.RF_B, 32'h7777_0001);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            v.rst          = ($urandom_range(0, 39) == 0);
            v.instr        = $urandom;
            v.instr[25:21] = 5'($urandom_range(0, 7));
            v.instr[20:16] = 5'($urandom_range(0, 7));
            v.instr[15:11] = 5'($urandom_range(0, 7));
            v.alu          = $urandom;
            v.mem          = $urandom;
            v.wren         = 1'($urandom_range(0, 1));
            v.wsel         = 1'($urandom_range(0, 1));
            v.bsel         = 1'($urandom_range(0, 1));
            v.ext          = 2'($urandom_range(0, 3));
            v.ld           = ($urandom_range(0, 3) != 0);
            apply(v);
            check($sformatf("rand%0d RF_A", n),  bus.RF_A,  m_a);
            check($sformatf("rand%0d RF_B", n),  bus.RF_B,  m_b);
            check($sformatf("rand%0d Immed", n), bus.Immed, m_imm);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Decode stage of the CHARIS multicycle datapath. It sits directly downstream of the fetch stage and consumes its 32-bit Instr.
- Holds the 32x32 register file, performs write-back, and generates the extended immediate.
- Latches operands A/B and Immed into stage output registers for the execute stage.
- Its Immed output also drives the fetch stage's PC_Immed for branch targets.

Parameters:
- REG_COUNT, 32, number of architectural registers (R0 hardwired to zero)
- DATA_W, 32, register and datapath width

Ports:
- Clk  input  1  single system clock, rising edge
- Reset  input  1  synchronous, active-high reset
- Instr  input  32  current instruction from fetch stage
- ALU_out  input  32  write-back candidate from execute stage
- MEM_out  input  32  write-back candidate from memory stage
- RF_WrEn  input  1  register-file write enable
- RF_WrData_sel  input  1  0: write ALU_out, 1: write MEM_out
- RF_B_sel  input  1  0: read port B addresses rt, 1: addresses rd
- ImmExt  input  2  immediate extension mode
- Dec_LdEn  input  1  load enable for RF_A/RF_B/Immed output registers
- RF_A  output  32  registered operand A
- RF_B  output  32  registered operand B
- Immed  output  32  registered extended immediate

Behaviour:
- Fields: opcode=Instr[31:26], rs=Instr[25:21], rd=Instr[20:16], rt=Instr[15:11], imm16=Instr[15:0].
- Read addresses: port A uses rs. Port B uses rt when RF_B_sel=0 and rd when RF_B_sel=1. Reads are combinational from the array.
- Write: on a rising Clk with RF_WrEn=1, reg[rd] <= (RF_WrData_sel ? MEM_out : ALU_out). The write address is always rd.
- R0: writes to address 0 are discarded. Reading R0 always returns 0.
- ImmExt encodings:
  - 00: zero-extend imm16.
  - 01: sign-extend imm16.
  - 10: imm16 << 16, low half zero (lui).
  - 11: sign-extend imm16 then << 2 (branch offset). Bits shifted past bit 31 are dropped.
- Output registers: on a rising Clk with Dec_LdEn=1, RF_A, RF_B and Immed load their new values. With Dec_LdEn=0 they hold.
- Latency: Instr to RF_A/RF_B/Immed is 1 cycle.
- Write-first bypass: if RF_WrEn=1, Dec_LdEn=1 and a read address equals a nonzero rd in the same cycle, the output register loads the new write data, not the stale array value.
  - RF_B bypasses only when its selected address matches.
  - Address 0 is never bypassed.
- Reset: when Reset=1 at a rising edge, all registers, RF_A, RF_B and Immed become 0. Reset has priority over RF_WrEn and Dec_LdEn in the same cycle.
  - Reset asserted mid-instruction discards any pending write.
  - The first write after reset deasserts takes effect normally.
- Simultaneous RF_WrEn and Dec_LdEn with unrelated addresses: both take effect independently.
- X on RF_WrData_sel or ImmExt while the corresponding enable is low has no effect on state.

Decomposition:
- Shared package:
  - instruction field bit positions (opcode/rs/rd/rt/imm16 ranges);
  - ImmExt encodings (IMM_ZERO=2'b00, IMM_SIGN=2'b01, IMM_LUI=2'b10, IMM_BR=2'b11);
  - DATA_W.
- One sub-module: register_file
  - 2 combinational read ports, 1 synchronous write port, R0 forced to zero, synchronous reset clear.
  - Bypass muxing, immediate extension and output registers remain in decode_stage.

Test Plan:
- Reset, then Dec_LdEn=1 with Instr=0x0062_1800 -> RF_A=0, RF_B=0, Immed=0x0000_1800 (ImmExt=00), all registers read 0.
- RF_WrEn=1, RF_WrData_sel=0, ALU_out=0xDEAD_BEEF, rd=5; next cycle rs=5, Dec_LdEn=1 -> RF_A=0xDEAD_BEEF one cycle later. Repeating with rd=0 -> reading R0 gives 0.
- Same-cycle write-first: RF_WrEn=1, RF_WrData_sel=1, MEM_out=0x1234_5678, rd=7, RF_B_sel=1, Dec_LdEn=1 -> RF_B=0x1234_5678 after that edge.
- ImmExt sweep with imm16=0xFFFC:
  - 00 -> 0x0000_FFFC
  - 01 -> 0xFFFF_FFFC
  - 10 -> 0xFFFC_0000
  - 11 -> 0xFFFF_FFF0
- Dec_LdEn=0 while Instr and register contents change -> RF_A/RF_B/Immed hold previous values. Setting Dec_LdEn=1 updates them after 1 edge.
- Reset=1 coincident with RF_WrEn=1 to rd=3 and Dec_LdEn=1 -> reg3=0 and all outputs 0 after the edge. The write is lost.
